inst_loader: RTL
================

// Module: inst_loader
// PURPOSE
//  Write-side companion of the instruction memory: receives a program image as a
//  byte stream (valid/ready) and writes it word-by-word into the instruction RAM.
//  Holds the CPU in stall while loading and verifies an XOR checksum. Sits between
//  the debug/UART byte link and the write port of the instruction memory.
// PARAMETERS
//  ADDR_WIDTH  6   word-address width of the instruction memory (capacity 2^ADDR_WIDTH words)
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst         in   1   synchronous, active-high reset
//  start       in   1   one-cycle pulse: begin a new load (honoured in IDLE/DONE/ERR only)
//  byte_valid  in   1   source has a byte on byte_data
//  byte_data   in   8   stream byte
//  byte_ready  out  1   loader accepts byte this cycle; transfer = byte_valid & byte_ready
//  mem_we      out  1   instruction-memory write strobe, one cycle per word
//  mem_addr    out  32  word address, zero-extended from ADDR_WIDTH bits
//  mem_din     out  32  word to write
//  cpu_hold    out  1   stall/hold CPU fetch while high
//  load_done   out  1   image written and checksum matched (sticky)
//  load_err    out  1   length overflow or checksum mismatch (sticky)
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-high. On rst: state IDLE,
//   byte_ready=0, mem_we=0, mem_addr=0, mem_din=0, cpu_hold=0, load_done=0, load_err=0,
//   byte counter, word counter, length and checksum registers cleared.
//  Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data
//   bytes (each word little-endian: first byte -> din[7:0]), then 1 checksum byte
//   = XOR of all 4*N data bytes (length bytes excluded).
//  States: IDLE, LEN0, LEN1, DATA, CHECK, DONE, ERR.
//   IDLE/DONE/ERR --start--> LEN0; clears counters, checksum, load_done, load_err;
//    cpu_hold=1 from the next cycle.
//   LEN0 --xfer--> LEN1 (latch LEN_LO).
//   LEN1 --xfer--> N > 2^ADDR_WIDTH: ERR; N == 0: CHECK; else DATA.
//   DATA: each xfer shifts byte into assembly reg and XORs it into checksum; on 4th byte
//    of a word -> next cycle mem_we=1 for exactly one cycle with mem_addr=word index,
//    mem_din=assembled word; word index++ afterwards. byte_ready stays high during
//    the write (no stall). After the 4th byte of word N-1 -> CHECK.
//   CHECK --xfer--> byte == checksum: DONE; else ERR.
//   DONE: load_done=1, cpu_hold=0. ERR: load_err=1, cpu_hold stays 1.
//  byte_ready = 1 exactly in LEN0, LEN1, DATA, CHECK; 0 elsewhere (bytes ignored).
//  start while in LEN0..CHECK is ignored. start and rst together: rst wins.
//  Word counter width ADDR_WIDTH+1; no wrap: N == 2^ADDR_WIDTH is legal, last addr
//   = 2^ADDR_WIDTH-1.
//  Reset mid-load: back to IDLE next edge, mem_we=0; already-written words remain in
//   memory (not rolled back); a pending write scheduled for that cycle is dropped.
//  byte_valid low stalls the FSM indefinitely in the current state; no timeout.
// TESTING
//  1 N=1, bytes 78 56 34 12, cksum 78^56^34^12=0x08 -> one mem_we, addr 0,
//    din 0x12345678; load_done=1, cpu_hold=0.
//  2 N=2 with byte_valid toggling every other cycle -> writes at addr 0,1 in order,
//    exactly two mem_we pulses, load_done=1.
//  3 N=1, correct data, checksum 0xFF -> load_err=1, cpu_hold=1, byte_ready=0 after.
//  4 LEN=0x0041 with ADDR_WIDTH=6 -> ERR right after LEN_HI, no mem_we ever;
//    LEN=0x0040 -> 64 writes, last addr 63, done.
//  5 N=0, checksum 0x00 -> DONE with no writes; start pulsed mid-DATA -> ignored.
//  6 rst asserted after 2nd word's 3rd byte -> next cycle IDLE, all outputs at reset
//    values, no further mem_we; new start then full load succeeds.

Source files
------------

// File: rtl/inst_loader.sv
// inst_loader: receives a program image as a valid/ready byte stream and writes it
// word-by-word into the instruction RAM. It holds the CPU while loading and
// verifies an XOR checksum that trails the data bytes.
`timescale 1ns/1ps
module inst_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam int          CW       = ADDR_WIDTH + 1;
  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  // Running XOR checksum over the data bytes.
  function automatic logic [7:0] cksum_update(input logic [7:0] cur, input logic [7:0] b);
    return cur ^ b;
  endfunction

  // States in which the loader consumes stream bytes.
  function automatic logic accepts_bytes(input state_t s);
    case (s)
      LEN0, LEN1, DATA, CHECK: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

  // The CPU runs only when idle or after a successful load; an error keeps it held.
  function automatic logic holds_cpu(input state_t s);
    case (s)
      IDLE, DONE: return 1'b0;
      default:    return 1'b1;
    endcase
  endfunction

  state_t         state, state_n;
  logic [7:0]     len_lo, len_lo_n;
  logic [15:0]    len, len_n;
  logic [1:0]     byte_cnt, byte_cnt_n;
  logic [CW-1:0]  word_cnt, word_cnt_n;
  logic [7:0]     cksum, cksum_n;
  logic [23:0]    asm_word, asm_word_n;
  logic           we_n;
  logic [31:0]    addr_n, din_n;
  logic           xfer;
  logic [15:0]    len_word;
  logic [31:0]    words_done;

  // Next-state and datapath computation; outputs are registered from these values.
  always_comb begin
    xfer       = byte_valid & byte_ready;
    len_word   = {byte_data, len_lo};
    words_done = 32'(word_cnt) + 32'd1;
    state_n    = state;
    len_lo_n   = len_lo;
    len_n      = len;
    byte_cnt_n = byte_cnt;
    word_cnt_n = word_cnt;
    cksum_n    = cksum;
    asm_word_n = asm_word;
    we_n       = 1'b0;
    addr_n     = mem_addr;
    din_n      = mem_din;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_n    = LEN0;
          len_lo_n   = 8'd0;
          len_n      = 16'd0;
          byte_cnt_n = 2'd0;
          word_cnt_n = {CW{1'b0}};
          cksum_n    = 8'd0;
          asm_word_n = 24'd0;
        end else begin
          state_n = state;
        end
      end
      LEN0: begin
        if (xfer) begin
          len_lo_n = byte_data;
          state_n  = LEN1;
        end else begin
          state_n = LEN0;
        end
      end
      LEN1: begin
        if (xfer) begin
          len_n = len_word;
          if (32'(len_word) > CAPACITY) begin
            state_n = ERR;
          end else if (len_word == 16'd0) begin
            state_n = CHECK;
          end else begin
            state_n = DATA;
          end
        end else begin
          state_n = LEN1;
        end
      end
      DATA: begin
        if (xfer) begin
          cksum_n = cksum_update(cksum, byte_data);
          if (byte_cnt == 2'd3) begin
            // Word complete: schedule the write for the next cycle.
            we_n       = 1'b1;
            addr_n     = 32'(word_cnt[ADDR_WIDTH-1:0]);
            din_n      = {byte_data, asm_word};
            word_cnt_n = words_done[CW-1:0];
            byte_cnt_n = 2'd0;
            if (words_done == 32'(len)) begin
              state_n = CHECK;
            end else begin
              state_n = DATA;
            end
          end else begin
            // Little-endian assembly: first byte ends up in bits [7:0].
            asm_word_n = {byte_data, asm_word[23:8]};
            byte_cnt_n = byte_cnt + 2'd1;
          end
        end else begin
          state_n = DATA;
        end
      end
      CHECK: begin
        if (xfer) begin
          if (byte_data == cksum) begin
            state_n = DONE;
          end else begin
            state_n = ERR;
          end
        end else begin
          state_n = CHECK;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_lo     <= 8'd0;
      len        <= 16'd0;
      byte_cnt   <= 2'd0;
      word_cnt   <= {CW{1'b0}};
      cksum      <= 8'd0;
      asm_word   <= 24'd0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_din    <= 32'd0;
      byte_ready <= 1'b0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_n;
      len_lo     <= len_lo_n;
      len        <= len_n;
      byte_cnt   <= byte_cnt_n;
      word_cnt   <= word_cnt_n;
      cksum      <= cksum_n;
      asm_word   <= asm_word_n;
      mem_we     <= we_n;
      mem_addr   <= addr_n;
      mem_din    <= din_n;
      byte_ready <= accepts_bytes(state_n);
      cpu_hold   <= holds_cpu(state_n);
      load_done  <= (state_n == DONE);
      load_err   <= (state_n == ERR);
    end
  end

endmodule
